// File: rtl/seg_pkg.sv
// Shared glyph constants for the seven-segment scan decoder and its encoder.
package seg_pkg;

    // Active-low glyphs, bit order gfedcba (bit 6 = g).
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] DIGIT_BLANK = 4'hE;
    localparam logic [3:0] DIGIT_ERR   = 4'hF;

    // Forward encoder; anything that is not a decimal digit shows as blank.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = GLYPH_0;
            4'd1:    pattern = GLYPH_1;
            4'd2:    pattern = GLYPH_2;
            4'd3:    pattern = GLYPH_3;
            4'd4:    pattern = GLYPH_4;
            4'd5:    pattern = GLYPH_5;
            4'd6:    pattern = GLYPH_6;
            4'd7:    pattern = GLYPH_7;
            4'd8:    pattern = GLYPH_8;
            4'd9:    pattern = GLYPH_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational map from an active-low segment pattern to a digit code.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_err,
    output logic       o_blank
);

    // Unknown patterns fall through to the error code.
    always_comb begin
        o_value = DIGIT_ERR;
        o_err   = 1'b1;
        o_blank = 1'b0;
        case (i_seg)
            GLYPH_0:   begin o_value = 4'd0; o_err = 1'b0; end
            GLYPH_1:   begin o_value = 4'd1; o_err = 1'b0; end
            GLYPH_2:   begin o_value = 4'd2; o_err = 1'b0; end
            GLYPH_3:   begin o_value = 4'd3; o_err = 1'b0; end
            GLYPH_4:   begin o_value = 4'd4; o_err = 1'b0; end
            GLYPH_5:   begin o_value = 4'd5; o_err = 1'b0; end
            GLYPH_6:   begin o_value = 4'd6; o_err = 1'b0; end
            GLYPH_7:   begin o_value = 4'd7; o_err = 1'b0; end
            GLYPH_8:   begin o_value = 4'd8; o_err = 1'b0; end
            GLYPH_9:   begin o_value = 4'd9; o_err = 1'b0; end
            SEG_BLANK: begin o_value = DIGIT_BLANK; o_err = 1'b0; o_blank = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed active-low 7-segment
// display and hands them out as frames through a valid/ready handshake.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overflow
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic [3:0]  r_prev_an;
    logic [6:0]  r_prev_seg;
    logic [7:0]  r_cnt;
    logic [15:0] r_work_val;
    logic [3:0]  r_work_err;
    logic [3:0]  r_seen;
    logic [15:0] r_digits;
    logic [3:0]  r_digit_err;
    logic        r_frame_valid;
    logic        r_overflow;

    logic        w_qual;
    logic [1:0]  w_slot;
    logic        w_same;
    logic [7:0]  w_cnt_next;
    logic        w_capture;
    logic        w_complete;
    logic        w_accept;
    logic        w_load;
    logic [3:0]  w_seen_next;
    logic [3:0]  w_dec_val;
    logic        w_dec_err;
    logic        w_dec_blank;
    logic [3:0]  w_slot_val;

    seg_pattern_decode u_decode (
        .i_seg   (r_seg),
        .o_value (w_dec_val),
        .o_err   (w_dec_err),
        .o_blank (w_dec_blank)
    );

    assign w_slot_val = w_dec_blank ? DIGIT_BLANK : w_dec_val;

    // Only a single low enable bit identifies a slot.
    always_comb begin
        w_qual = 1'b1;
        w_slot = 2'd0;
        case (r_an)
            4'b1110: w_slot = 2'd0;
            4'b1101: w_slot = 2'd1;
            4'b1011: w_slot = 2'd2;
            4'b0111: w_slot = 2'd3;
            default: w_qual = 1'b0;
        endcase
    end

    assign w_same = ({r_an, r_seg} == {r_prev_an, r_prev_seg});

    // Run-length counter; saturation makes the capture fire once per run.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_qual)
            w_cnt_next = 8'd0;
        else if (w_same && (r_cnt != 8'd0))
            w_cnt_next = (r_cnt == STABLE_LIM) ? r_cnt : r_cnt + 8'd1;
        else
            w_cnt_next = 8'd1;
    end

    assign w_capture  = w_qual && (w_cnt_next == STABLE_LIM) && (r_cnt != STABLE_LIM);
    assign w_complete = &r_seen;
    assign w_accept   = r_frame_valid && frame_ready;
    assign w_load     = w_complete && (!r_frame_valid || frame_ready);

    // Completion clears the seen set whether the frame is loaded or dropped.
    always_comb begin
        w_seen_next = w_complete ? 4'b0000 : r_seen;
        if (w_capture)
            w_seen_next[w_slot] = 1'b1;
    end

    // Input sample stage and previous-sample copy for the stability compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an       <= 4'hF;
            r_seg      <= SEG_BLANK;
            r_prev_an  <= 4'hF;
            r_prev_seg <= SEG_BLANK;
            r_cnt      <= 8'd0;
        end else begin
            r_an       <= an;
            r_seg      <= seg;
            r_prev_an  <= r_an;
            r_prev_seg <= r_seg;
            r_cnt      <= w_cnt_next;
        end
    end

    // Working slots collect captures until all four have been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work_val <= 16'h0000;
            r_work_err <= 4'h0;
            r_seen     <= 4'h0;
        end else begin
            r_seen <= w_seen_next;
            for (int i = 0; i < 4; i++) begin
                if (w_capture && (w_slot == 2'(i))) begin
                    r_work_val[4*i +: 4] <= w_slot_val;
                    r_work_err[i]        <= w_dec_err;
                end
            end
        end
    end

    // Output frame register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits      <= 16'h0000;
            r_digit_err   <= 4'h0;
            r_frame_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_load) begin
                r_digits      <= r_work_val;
                r_digit_err   <= r_work_err;
                r_frame_valid <= 1'b1;
            end else if (w_accept) begin
                r_frame_valid <= 1'b0;
            end
            if (w_accept)
                r_overflow <= 1'b0;
            else if (w_complete && r_frame_valid)
                r_overflow <= 1'b1;
        end
    end

    assign digits      = r_digits;
    assign digit_err   = r_digit_err;
    assign frame_valid = r_frame_valid;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: stimulus predicts frames from run lengths of the held
// display inputs; a monitor pops and compares each frame as it is accepted.
module tb_seg_scan_decoder;

    localparam int S = 4;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  e;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        frame_ready = 1'b1;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    // Reference model state
    frame_t     exp_q[$];
    logic [3:0] m_prev_an;
    logic [6:0] m_prev_seg;
    bit         m_prev_valid = 0;
    int         m_run = 0;
    logic [3:0] m_val [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic       m_err [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] m_seen = 4'h0;
    bit         m_hold = 0;
    bit         m_pending = 0;
    logic       exp_ovf = 1'b0;

    bit         rnd_ready = 0;
    logic       ready_force = 1'b1;
    int         low_run = 0;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] v, output logic e);
        v = 4'hF;
        e = 1'b1;
        if (s == 7'h7F) begin
            v = 4'hE;
            e = 1'b0;
        end
        for (int i = 0; i < 10; i++)
            if (s == glyph_tab[i]) begin
                v = 4'(i);
                e = 1'b0;
            end
    endfunction

    function automatic logic [3:0] an_of(input int s);
        logic [3:0] t;
        t = 4'b0001 << s;
        return ~t;
    endfunction

    // Hold one {an,seg} value for n clock edges and update the model.
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        bit qual;
        bit same;
        int old_run;
        int slot;
        logic [3:0] v;
        logic e;
        frame_t f;
        qual = ($countones(~a) == 1);
        same = m_prev_valid && (a == m_prev_an) && (s == m_prev_seg);
        if (qual) begin
            old_run = same ? m_run : 0;
            m_run = old_run + n;
            if (old_run < S && m_run >= S) begin
                slot = 0;
                for (int i = 0; i < 4; i++) if (!a[i]) slot = i;
                model_decode(s, v, e);
                m_val[slot] = v;
                m_err[slot] = e;
                m_seen[slot] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_seen = 4'h0;
                    f.d = {m_val[3], m_val[2], m_val[1], m_val[0]};
                    f.e = {m_err[3], m_err[2], m_err[1], m_err[0]};
                    if (m_hold && m_pending) begin
                        exp_ovf = 1'b1;
                    end else begin
                        exp_q.push_back(f);
                        if (m_hold) m_pending = 1;
                    end
                end
            end
        end else begin
            m_run = 0;
        end
        m_prev_an = a;
        m_prev_seg = s;
        m_prev_valid = qual;
        an = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    task automatic scan(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3, input int n);
        drive(an_of(0), glyph_tab[d0], n);
        drive(an_of(1), glyph_tab[d1], n);
        drive(an_of(2), glyph_tab[d2], n);
        drive(an_of(3), glyph_tab[d3], n);
    endtask

    // frame_ready: forced value, or random with at most three low cycles in a row.
    always @(posedge clk) begin
        #2;
        if (rnd_ready) begin
            if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
                frame_ready = 1'b1;
                low_run = 0;
            end else begin
                frame_ready = 1'b0;
                low_run++;
            end
        end else begin
            frame_ready = ready_force;
        end
    end

    // Monitor: a frame is consumed on the edge following valid&ready.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            frame_t f;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", {16'h0, digits}, 32'hFFFF_FFFF);
            end else begin
                f = exp_q.pop_front();
                frames_seen++;
                check("frame_digits", {16'h0, digits}, {16'h0, f.d});
                check("frame_err", {28'h0, digit_err}, {28'h0, f.e});
            end
        end
    end

    initial begin
        int fs0;
        frame_t held;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", {16'h0, digits}, 32'h0);
        check("reset_err", {28'h0, digit_err}, 32'h0);
        check("reset_valid", {31'h0, frame_valid}, 32'h0);
        check("reset_ovf", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic 1,2,3,4 scan produces exactly one frame 4321
        fs0 = frames_seen;
        scan(4'd1, 4'd2, 4'd3, 4'd4, 8);
        idle(6);
        check("scan_frame_count", frames_seen - fs0, 1);
        check("scan_queue_empty", exp_q.size(), 0);

        // Stability boundary: 3 cycles ignored, 4 cycles captured
        drive(an_of(0), glyph_tab[5], 8);
        drive(an_of(0), glyph_tab[7], 3);
        drive(an_of(1), glyph_tab[0], 8);
        drive(an_of(2), glyph_tab[9], 8);
        drive(an_of(3), glyph_tab[8], 8);
        idle(6);
        drive(an_of(0), glyph_tab[6], 4);
        drive(an_of(1), glyph_tab[2], 8);
        drive(an_of(2), glyph_tab[2], 8);
        drive(an_of(3), glyph_tab[2], 8);
        idle(6);

        // Illegal and blank glyphs in slot 2
        drive(an_of(0), glyph_tab[1], 6);
        drive(an_of(1), glyph_tab[1], 6);
        drive(an_of(2), 7'b0101010, 6);
        drive(an_of(3), glyph_tab[1], 6);
        idle(6);
        drive(an_of(0), glyph_tab[3], 6);
        drive(an_of(1), glyph_tab[3], 6);
        drive(an_of(2), 7'h7F, 6);
        drive(an_of(3), glyph_tab[3], 6);
        idle(6);

        // Non-qualifying enables do not capture or disturb seen bits
        drive(an_of(0), glyph_tab[9], 8);
        drive(an_of(1), glyph_tab[8], 8);
        drive(4'b0011, glyph_tab[7], 10);
        drive(4'hF, glyph_tab[6], 10);
        drive(an_of(2), glyph_tab[5], 8);
        drive(an_of(3), glyph_tab[4], 8);
        idle(6);
        check("pre_hold_queue_empty", exp_q.size(), 0);

        // Backpressure: two scans with ready low, second one overflows
        ready_force = 1'b0;
        m_hold = 1;
        idle(2);
        scan(4'd7, 4'd6, 4'd5, 4'd4, 6);
        scan(4'd0, 4'd1, 4'd2, 4'd3, 6);
        idle(6);
        held = exp_q[0];
        check("hold_valid", {31'h0, frame_valid}, 32'h1);
        check("hold_digits", {16'h0, digits}, {16'h0, held.d});
        check("hold_err", {28'h0, digit_err}, {28'h0, held.e});
        check("hold_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        exp_ovf = 1'b0;
        m_hold = 0;
        m_pending = 0;
        check("accept_valid", {31'h0, frame_valid}, 32'h0);
        check("accept_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
        idle(2);
        ready_force = 1'b1;
        idle(2);

        // Reset with three slots captured discards the partial frame
        drive(an_of(0), glyph_tab[2], 6);
        drive(an_of(1), glyph_tab[4], 6);
        drive(an_of(2), glyph_tab[6], 6);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_digits", {16'h0, digits}, 32'h0);
        check("midrst_err", {28'h0, digit_err}, 32'h0);
        check("midrst_valid", {31'h0, frame_valid}, 32'h0);
        check("midrst_ovf", {31'h0, overflow}, 32'h0);
        check("midrst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        m_prev_valid = 0;
        m_run = 0;
        m_seen = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_val[i] = 4'h0;
            m_err[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fs0 = frames_seen;
        scan(4'd8, 4'd7, 4'd6, 4'd5, 8);
        idle(6);
        check("post_rst_frame_count", frames_seen - fs0, 1);

        // Randomized scanning with random backpressure
        rnd_ready = 1;
        for (int k = 0; k < 250; k++) begin
            logic [3:0] a;
            logic [6:0] s;
            int pick;
            if ($urandom_range(0, 9) == 0)
                a = 4'($urandom_range(0, 15));
            else
                a = an_of($urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            if (pick < 7)
                s = glyph_tab[$urandom_range(0, 9)];
            else if (pick == 7)
                s = 7'h7F;
            else
                s = 7'($urandom_range(0, 127));
            drive(a, s, $urandom_range(1, 9));
        end
        idle(8);
        rnd_ready = 0;
        ready_force = 1'b1;
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        idle(4);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ovf", {31'h0, overflow}, 32'h0);
        check("final_valid", {31'h0, frame_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: the number of consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 an  input  4  digit enables of a time-multiplexed display, active-low; bit i selects slot i.
REQ-005 seg  input  7  segment lines, active-low, bit order gfedcba (bit 6 = g).
REQ-006 digits  output  16  captured frame; slot i occupies bits [4i+3:4i].
REQ-007 digit_err  output  4  per-slot flag: the captured pattern was not a legal glyph.
REQ-008 frame_valid  output  1  digits and digit_err hold a complete frame.
REQ-009 frame_ready  input  1  consumer accepts the frame.
REQ-010 overflow  output  1  sticky flag: a completed frame was dropped while the previous frame was pending.

Function
REQ-011 The block shall register an and seg once (sample stage) before any decision; all latencies below count from that sample.
REQ-012 A sample shall be qualifying only when an has exactly one bit low; all other an values reset the stability counter and capture nothing.
REQ-013 The stability counter shall increment while the sampled {an,seg} equals the previous sample, and shall reload to 1 on any change.
REQ-014 The block shall capture a slot on the edge at which the counter reaches STABLE_CYCLES; it shall capture at most once per stable run until {an,seg} changes.
REQ-015 Decode map (active-low gfedcba -> value): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-016 The pattern 1111111 shall decode to 4'hE (blank) with err=0.
REQ-017 Any other pattern shall decode to 4'hF with err=1.
REQ-018 Each capture shall write the decoded value and err into the working slot and set that slot's seen bit.
REQ-019 When all four seen bits are set and frame_valid=0, the working slots shall be copied to digits/digit_err on the next edge, frame_valid shall go to 1, and all seen bits shall clear.
REQ-020 Handshake: the frame is accepted on any edge with frame_valid=1 and frame_ready=1; frame_valid shall then drop on that edge unless a new frame completes on the same edge, in which case the new frame loads and frame_valid stays 1.
REQ-021 While frame_valid=1 and frame_ready=0, digits and digit_err shall hold steady and capture into the working slots shall continue.
REQ-022 If four seen bits complete while a frame is pending, overflow shall set, the seen bits shall clear, and that frame shall be discarded.
REQ-023 overflow shall clear only on reset or on a frame acceptance.
REQ-024 The stability counter shall saturate at STABLE_CYCLES and shall not wrap.

Reset
REQ-025 Asserting rst shall immediately clear: digits=16'h0000, digit_err=0, frame_valid=0, overflow=0, seen bits=0, working slots=0, counter=0, and the sample registers to an=4'hF, seg=7'h7F.
REQ-026 A reset asserted mid-run shall discard any partial frame and any pending frame; after deassertion the first capture shall require a full STABLE_CYCLES run.

Structure
REQ-027 A shared package seg_pkg shall hold the ten glyph constants, SEG_BLANK=7'h7F, DIGIT_BLANK=4'hE and DIGIT_ERR=4'hF; the forward digit-to-segment encoder shall use the same constants.
REQ-028 A combinational sub-module seg_pattern_decode shall map seg[6:0] to value[3:0], err and blank; seg_scan_decoder shall instantiate it once on the sampled seg.

Verification
REQ-029 Scan 1,2,3,4 across slots 0..3 with 8 cycles per slot and frame_ready=1 -> a single frame_valid pulse with digits=16'h4321 and digit_err=0.
REQ-030 With STABLE_CYCLES=4, hold slot 0 for 3 cycles then switch -> no capture; hold for 4 cycles -> captured.
REQ-031 Drive slot 2 with seg=7'b0101010 -> that nibble=F, digit_err=4'b0100; drive seg=7'h7F -> nibble=E, err=0.
REQ-032 Hold frame_ready=0 across two complete scans -> the first frame is held unchanged and overflow=1; set frame_ready=1 for one cycle -> frame_valid=0 and overflow=0.
REQ-033 Apply an=4'b0011 or an=4'hF for 10 cycles -> no capture and seen bits unchanged.
REQ-034 Assert rst after 3 slots have been captured -> all outputs are zero immediately; a following full scan produces the correct frame.
